// File: rtl/euclid_pkg.sv
// Shared definitions for the Euclidean datapath: FSM encoding, default widths, length legality.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package euclid_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LW_DEF    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } align_state_e;

  // A request is legal when both lengths fit the operand width and the
  // target is not shorter than the operand (no right shifts are supported).
  function automatic logic len_legal(input int op_len, input int tgt_len, input int width);
    return (op_len <= width) && (tgt_len <= width) && (tgt_len >= op_len);
  endfunction

endpackage

// File: rtl/length_align_step.sv
// One shift step of the aligner: applies min(rem, STEP) left shift with zero fill.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
// Ports: res_i/rem_i current value and remaining shift; res_o/rem_o after this step;
//        last_o high when this step consumes the remaining shift.
module length_align_step #(
  parameter int WIDTH = 32,
  parameter int LW    = 6,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0] res_i,
  input  logic [LW-1:0]    rem_i,
  output logic [WIDTH-1:0] res_o,
  output logic [LW-1:0]    rem_o,
  output logic             last_o
);

  localparam logic [LW-1:0] STEP_L = LW'(STEP);

  logic [LW-1:0] amt;

  assign amt    = (rem_i < STEP_L) ? rem_i : STEP_L;
  assign res_o  = res_i << amt;
  assign rem_o  = rem_i - amt;
  assign last_o = (rem_o == '0);

endmodule

// File: rtl/length_align.sv
// Left-aligns an operand so its MSB sits at bit tgt_len-1, shifting at most STEP bits per cycle.
// Latency: out_valid first seen 1+ceil(d/STEP) cycles after accept (1 cycle for d==0 or illegal).
// Backpressure: one request in flight; result held in DONE until out_ready, in_ready low outside IDLE.
// Ports: clk/rst_n clock and async active-low reset; in_valid/in_ready/op/op_len/tgt_len request side;
//        out_valid/out_ready/result/shift_amt/err response side (err: illegal lengths, op passed through).
module length_align
  import euclid_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LW    = LW_DEF,   // 2**LW must exceed WIDTH
  parameter int STEP  = 4         // 1..WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op,
  input  logic [LW-1:0]    op_len,
  input  logic [LW-1:0]    tgt_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [LW-1:0]    shift_amt,
  output logic             err
);

  align_state_e     state_q;
  logic [WIDTH-1:0] result_q;
  logic [LW-1:0]    shift_amt_q;
  logic [LW-1:0]    rem_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             accept;
  logic             req_legal;
  logic [LW-1:0]    diff;
  logic [WIDTH-1:0] result_step_d;
  logic [LW-1:0]    rem_step_d;
  logic             step_last;

  assign accept    = in_valid & in_ready_q;
  assign req_legal = len_legal(int'(op_len), int'(tgt_len), WIDTH);
  // Only meaningful when req_legal, which guarantees tgt_len >= op_len.
  assign diff      = tgt_len - op_len;

  length_align_step #(
    .WIDTH (WIDTH),
    .LW    (LW),
    .STEP  (STEP)
  ) u_step (
    .res_i  (result_q),
    .rem_i  (rem_q),
    .res_o  (result_step_d),
    .rem_o  (rem_step_d),
    .last_o (step_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      shift_amt_q <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            result_q   <= op;
            if (!req_legal) begin
              err_q       <= 1'b1;
              shift_amt_q <= '0;
              rem_q       <= '0;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              err_q       <= 1'b0;
              shift_amt_q <= diff;
              rem_q       <= diff;
              if (diff == '0) begin
                out_valid_q <= 1'b1;
                state_q     <= ST_DONE;
              end else begin
                state_q <= ST_SHIFT;
              end
            end
          end else begin
            // Covers the first edge after reset release as well as idle cycles.
            in_ready_q <= 1'b1;
          end
        end

        ST_SHIFT: begin
          result_q <= result_step_d;
          rem_q    <= rem_step_d;
          if (step_last) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end

        ST_DONE: begin
          // No accept in the same cycle: in_ready only returns on the next edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign shift_amt = shift_amt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_length_align.sv
// Directed table-driven bench for length_align plus hand-written hold and reset sequences.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_length_align;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op;
  logic [5:0]  op_len;
  logic [5:0]  tgt_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [5:0]  shift_amt;
  logic        err;

  int errors = 0;
  int checks = 0;

  length_align #(.WIDTH(32), .LW(6), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_len    (op_len),
    .tgt_len   (tgt_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .shift_amt (shift_amt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op;
    logic [5:0]  op_len;
    logic [5:0]  tgt_len;
    logic [31:0] exp_res;
    logic [5:0]  exp_shift;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request; returns the number of cycles until out_valid is seen
  // (1 = visible right after the accept edge).
  task automatic issue(input logic [31:0] o, input logic [5:0] l, input logic [5:0] t, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_req", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = o;
    op_len   = l;
    tgt_len  = t;
    @(posedge clk); #1;
    // Garbage after the accept edge: must not be sampled.
    in_valid = 1'b0;
    op       = 32'hDEADBEEF;
    op_len   = 6'h3F;
    tgt_len  = 6'h3F;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_release", 32'(out_valid), 32'd0);
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;

    vecs[0]  = '{32'h00000005,  6'd3,  6'd8, 32'h000000A0,  6'd5, 1'b0, 3};
    vecs[1]  = '{32'h80000000, 6'd32, 6'd32, 32'h80000000,  6'd0, 1'b0, 1};
    vecs[2]  = '{32'h00000001,  6'd1, 6'd32, 32'h80000000, 6'd31, 1'b0, 9};
    vecs[3]  = '{32'h0000003F,  6'd6,  6'd4, 32'h0000003F,  6'd0, 1'b1, 1};
    vecs[4]  = '{32'h0000003F,  6'd6, 6'd33, 32'h0000003F,  6'd0, 1'b1, 1};
    vecs[5]  = '{32'h00000000,  6'd0, 6'd16, 32'h00000000, 6'd16, 1'b0, 5};
    vecs[6]  = '{32'h00001234, 6'd33, 6'd33, 32'h00001234,  6'd0, 1'b1, 1};
    vecs[7]  = '{32'h00000003,  6'd2,  6'd6, 32'h00000030,  6'd4, 1'b0, 2};
    vecs[8]  = '{32'h000000FF,  6'd8, 6'd16, 32'h0000FF00,  6'd8, 1'b0, 3};
    vecs[9]  = '{32'h00000001,  6'd1,  6'd2, 32'h00000002,  6'd1, 1'b0, 2};
    vecs[10] = '{32'h000000F0,  6'd4,  6'd8, 32'h00000F00,  6'd4, 1'b0, 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    op_len    = '0;
    tgt_len   = '0;

    // Reset state.
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_shift_amt", 32'(shift_amt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_ready_first_edge", 32'(in_ready), 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].op_len, vecs[i].tgt_len, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("v%0d_shift_amt", i), 32'(shift_amt), 32'(vecs[i].exp_shift));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_in_ready_done", i), 32'(in_ready), 32'd0);
      release_out();
    end

    // Hold in DONE with out_ready low while in_valid toggles.
    issue(32'h5, 6'd3, 6'd8, lat);
    chk("hold_latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      op       = 32'h12345678;
      op_len   = 6'd5;
      tgt_len  = 6'd20;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_result", c), result, 32'hA0);
      chk($sformatf("hold%0d_shift_amt", c), 32'(shift_amt), 32'd5);
      chk($sformatf("hold%0d_err", c), 32'(err), 32'd0);
      chk($sformatf("hold%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    chk("hold_result_after_release", result, 32'hA0);
    @(posedge clk); #1;
    chk("hold_no_stray_request", 32'(out_valid), 32'd0);

    // Reset asserted in the middle of a long shift.
    in_valid = 1'b1;
    op       = 32'h1;
    op_len   = 6'd1;
    tgt_len  = 6'd32;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_shift_result_nonzero", 32'(result != 32'd0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_shift_amt", 32'(shift_amt), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rerst_in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rerst_in_ready_after_edge", 32'(in_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("rerst_request_abandoned", 32'(out_valid), 32'd0);

    // Normal operation after the abandoned request.
    issue(32'h5, 6'd3, 6'd8, lat);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_result", result, 32'hA0);
    chk("post_rst_shift_amt", 32'(shift_amt), 32'd5);
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
